// File: rtl/nios2_debug_ocimem_pkg.sv
// rtl/nios2_debug_ocimem_pkg.sv - shared types and jdo field positions for the debug memory controller
package nios2_debug_ocimem_pkg;

   typedef enum logic [2:0] {
      IDLE,
      J_RD,
      J_RD_DATA,
      J_WR,
      C_RD
   } ocimem_state_e;

   localparam int JDO_ADDR_LSB  = 26;
   localparam int JDO_RDREQ     = 34;
   localparam int JDO_WDATA_MSB = 34;
   localparam int JDO_WDATA_LSB = 3;

endpackage

// File: rtl/nios2_debug_ocimem_ram.sv
// rtl/nios2_debug_ocimem_ram.sv - single-port byte-writable debug RAM with registered read
module nios2_debug_ocimem_ram #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] addr,
   input  logic              we,
   input  logic [3:0]        be,
   input  logic [31:0]       wdata,
   output logic [31:0]       q
);

   logic [31:0] mem [0:(1<<ADDR_W)-1];

   // q always follows the presented address one cycle later; read-during-write returns old data
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (we && be[b]) begin
            mem[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
      q <= mem[addr];
   end

endmodule

// File: rtl/nios2_debug_ocimem.sv
// rtl/nios2_debug_ocimem.sv - JTAG debug RAM access with auto-increment address and CPU Avalon port
module nios2_debug_ocimem #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_no_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic [ADDR_W-1:0] avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [DATA_W-1:0] avs_writedata,
   input  logic [3:0]        avs_byteenable,
   input  logic              avs_debugaccess,
   output logic [DATA_W-1:0] avs_readdata,
   output logic              avs_waitrequest,
   output logic [DATA_W-1:0] MonDReg,
   output logic [ADDR_W-1:0] MonAReg,
   output logic              monitor_ready,
   output logic              jtag_overrun
);

   import nios2_debug_ocimem_pkg::*;

   ocimem_state_e     state;
   logic              pend_valid;
   logic              pend_wr;
   logic [DATA_W-1:0] pend_data;
   logic [DATA_W-1:0] rd_hold;
   logic [DATA_W-1:0] ram_q;
   logic [DATA_W-1:0] ram_wdata;
   logic [ADDR_W-1:0] ram_addr;
   logic [3:0]        ram_be;
   logic              ram_we;
   logic              jtag_busy;
   logic              strobe_any;
   logic              cpu_idle;
   logic              unused_jdo_bits;

   assign unused_jdo_bits = ^{jdo[37:35], jdo[2:0]};

   assign jtag_busy  = pend_valid || state == J_RD || state == J_RD_DATA || state == J_WR;
   assign strobe_any = take_action_ocimem_a || take_no_action_ocimem_a || take_action_ocimem_b;
   assign cpu_idle   = state == IDLE && !pend_valid;

   assign avs_waitrequest = !reset_n
                         || (avs_read && state != C_RD)
                         || (avs_write && !avs_read && !cpu_idle);
   assign avs_readdata = (state == C_RD) ? ram_q : rd_hold;

   always_comb begin
      ram_addr  = avs_address;
      ram_we    = 1'b0;
      ram_be    = avs_byteenable;
      ram_wdata = avs_writedata;
      case (state)
         J_WR: begin
            ram_addr  = MonAReg;
            ram_we    = 1'b1;
            ram_be    = 4'hF;
            ram_wdata = pend_data;
         end
         J_RD:    ram_addr = MonAReg;
         // CPU writes complete in place; without debugaccess they are acknowledged but discarded
         IDLE:    ram_we = reset_n && !pend_valid && !avs_read && avs_write && avs_debugaccess;
         default: ram_we = 1'b0;
      endcase
   end

   nios2_debug_ocimem_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk   (clk),
      .addr  (ram_addr),
      .we    (ram_we),
      .be    (ram_be),
      .wdata (ram_wdata),
      .q     (ram_q)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         pend_valid    <= 1'b0;
         pend_wr       <= 1'b0;
         pend_data     <= '0;
         rd_hold       <= '0;
         MonDReg       <= '0;
         MonAReg       <= '0;
         monitor_ready <= 1'b0;
         jtag_overrun  <= 1'b0;
      end else begin
         if (strobe_any && jtag_busy) begin
            jtag_overrun <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (pend_valid) begin
                  pend_valid <= 1'b0;
                  state      <= pend_wr ? J_WR : J_RD;
               end else if (avs_read) begin
                  state <= C_RD;
               end
            end
            J_WR: begin
               monitor_ready <= 1'b1;
               MonAReg       <= MonAReg + ADDR_W'(1);
               state         <= IDLE;
            end
            J_RD: state <= J_RD_DATA;
            J_RD_DATA: begin
               MonDReg       <= ram_q;
               monitor_ready <= 1'b1;
               MonAReg       <= MonAReg + ADDR_W'(1);
               state         <= IDLE;
            end
            C_RD: begin
               rd_hold <= ram_q;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
         // Accepted only when not busy, so this never collides with the dequeue or increment above
         if (strobe_any && !jtag_busy) begin
            if (take_action_ocimem_a) begin
               MonAReg       <= jdo[JDO_ADDR_LSB +: ADDR_W];
               jtag_overrun  <= 1'b0;
               monitor_ready <= !jdo[JDO_RDREQ];
               pend_valid    <= jdo[JDO_RDREQ];
               pend_wr       <= 1'b0;
            end else if (take_no_action_ocimem_a) begin
               pend_valid    <= 1'b1;
               pend_wr       <= 1'b0;
               monitor_ready <= 1'b0;
            end else begin
               pend_valid    <= 1'b1;
               pend_wr       <= 1'b1;
               pend_data     <= jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
               monitor_ready <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_nios2_debug_ocimem.sv
// tb/tb_nios2_debug_ocimem.sv - directed self-checking bench for nios2_debug_ocimem
module tb_nios2_debug_ocimem;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [37:0] jdo;
   logic        ta_a, tna_a, ta_b;
   logic [7:0]  avs_address;
   logic        avs_read, avs_write;
   logic [31:0] avs_writedata;
   logic [3:0]  avs_byteenable;
   logic        avs_debugaccess;
   logic [31:0] avs_readdata;
   logic        avs_waitrequest;
   logic [31:0] mon_dreg;
   logic [7:0]  mon_areg;
   logic        monitor_ready;
   logic        jtag_overrun;

   int checks   = 0;
   int failures = 0;
   int n;

   always #5 clk = ~clk;

   nios2_debug_ocimem #(.ADDR_W(8), .DATA_W(32)) dut (
      .clk                     (clk),
      .reset_n                 (reset_n),
      .jdo                     (jdo),
      .take_action_ocimem_a    (ta_a),
      .take_no_action_ocimem_a (tna_a),
      .take_action_ocimem_b    (ta_b),
      .avs_address             (avs_address),
      .avs_read                (avs_read),
      .avs_write               (avs_write),
      .avs_writedata           (avs_writedata),
      .avs_byteenable          (avs_byteenable),
      .avs_debugaccess         (avs_debugaccess),
      .avs_readdata            (avs_readdata),
      .avs_waitrequest         (avs_waitrequest),
      .MonDReg                 (mon_dreg),
      .MonAReg                 (mon_areg),
      .monitor_ready           (monitor_ready),
      .jtag_overrun            (jtag_overrun)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [37:0] jdo_a(input logic [7:0] addr, input logic rd);
      jdo_a = 38'd0;
      jdo_a[33:26] = addr;
      jdo_a[34] = rd;
   endfunction

   function automatic logic [37:0] jdo_b(input logic [31:0] d);
      jdo_b = 38'd0;
      jdo_b[34:3] = d;
   endfunction

   // returns in cycle 1 relative to the strobe
   task automatic jtag(input logic a, input logic na, input logic b, input logic [37:0] j);
      jdo = j; ta_a = a; tna_a = na; ta_b = b;
      step();
      ta_a = 1'b0; tna_a = 1'b0; ta_b = 1'b0;
   endtask

   task automatic cpu_write(input string tag, input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] be, input logic dbg);
      avs_address = a; avs_writedata = d; avs_byteenable = be; avs_debugaccess = dbg;
      avs_write = 1'b1;
      #1;
      chk({tag, "_wait"}, avs_waitrequest, 0);
      @(posedge clk); #1;
      avs_write = 1'b0;
   endtask

   task automatic cpu_read(input string tag, input logic [7:0] a, input logic [31:0] exp);
      avs_address = a; avs_read = 1'b1;
      #1;
      chk({tag, "_wait0"}, avs_waitrequest, 1);
      @(posedge clk); #1;
      chk({tag, "_wait1"}, avs_waitrequest, 0);
      chk({tag, "_data"}, avs_readdata, exp);
      avs_read = 1'b0;
      step();
   endtask

   initial begin
      reset_n = 1'b0; jdo = '0; ta_a = 0; tna_a = 0; ta_b = 0;
      avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0;
      avs_byteenable = 4'hF; avs_debugaccess = 1'b0;
      repeat (3) step();
      chk("rst_mondreg", mon_dreg, 0);
      chk("rst_monareg", mon_areg, 0);
      chk("rst_ready", monitor_ready, 0);
      chk("rst_overrun", jtag_overrun, 0);
      chk("rst_readdata", avs_readdata, 0);
      chk("rst_wait", avs_waitrequest, 1);
      reset_n = 1'b1;
      step();

      // address-only command
      jtag(1, 0, 0, jdo_a(8'h10, 0));
      chk("addr_only_areg", mon_areg, 32'h10);
      chk("addr_only_ready", monitor_ready, 1);

      // JTAG write: ready in cycle 3
      jtag(0, 0, 1, jdo_b(32'hCAFEF00D));
      chk("wr_ready_c1", monitor_ready, 0);
      step();
      chk("wr_ready_c2", monitor_ready, 0);
      step();
      chk("wr_ready_c3", monitor_ready, 1);
      chk("wr_areg_inc", mon_areg, 32'h11);

      // JTAG read: data in cycle 4
      jtag(1, 0, 0, jdo_a(8'h10, 1));
      chk("rd_ready_c1", monitor_ready, 0);
      step(); step();
      chk("rd_ready_c3", monitor_ready, 0);
      step();
      chk("rd_ready_c4", monitor_ready, 1);
      chk("rd_data", mon_dreg, 32'hCAFEF00D);
      chk("rd_areg_inc", mon_areg, 32'h11);

      // wrap from 0xFF
      cpu_write("cw0", 8'h00, 32'h0BADBEEF, 4'hF, 1);
      jtag(1, 0, 0, jdo_a(8'hFF, 0));
      jtag(0, 0, 1, jdo_b(32'hA5A50001));
      step(); step();
      chk("wrap_areg", mon_areg, 32'h00);
      jtag(0, 1, 0, '0);
      step(); step(); step();
      chk("wrap_rdnext", mon_dreg, 32'h0BADBEEF);
      chk("wrap_areg2", mon_areg, 32'h01);
      jtag(1, 0, 0, jdo_a(8'hFF, 1));
      step(); step(); step();
      chk("ff_data", mon_dreg, 32'hA5A50001);
      chk("ff_areg_wrap", mon_areg, 32'h00);

      // plain CPU read
      cpu_read("cr10", 8'h10, 32'hCAFEF00D);

      // JTAG pending vs CPU read: JTAG first, CPU data in cycle 5
      jtag(1, 0, 0, jdo_a(8'h10, 1));
      avs_address = 8'h10; avs_read = 1'b1;
      #1;
      chk("arb_wait_c1", avs_waitrequest, 1);
      n = 1;
      while (avs_waitrequest && n < 20) begin
         step();
         n++;
      end
      chk("arb_cycles", n, 5);
      chk("arb_cpu_data", avs_readdata, 32'hCAFEF00D);
      chk("arb_jtag_done", monitor_ready, 1);
      chk("arb_jtag_data", mon_dreg, 32'hCAFEF00D);
      avs_read = 1'b0;
      step();

      // overrun: second write strobe dropped
      cpu_write("cw31", 8'h31, 32'h31313131, 4'hF, 1);
      jtag(1, 0, 0, jdo_a(8'h30, 0));
      jdo = jdo_b(32'h11111111); ta_b = 1'b1;
      step();
      jdo = jdo_b(32'h22222222);
      step();
      ta_b = 1'b0;
      chk("ovr_set", jtag_overrun, 1);
      step();
      chk("ovr_ready", monitor_ready, 1);
      chk("ovr_areg", mon_areg, 32'h31);
      jtag(1, 0, 0, jdo_a(8'h30, 1));
      chk("ovr_cleared", jtag_overrun, 0);
      step(); step(); step();
      chk("ovr_first_lands", mon_dreg, 32'h11111111);
      jtag(0, 1, 0, '0);
      step(); step(); step();
      chk("ovr_next_intact", mon_dreg, 32'h31313131);

      // debugaccess gating and byte enables
      cpu_write("cw20a", 8'h20, 32'hDEADBEEF, 4'hF, 1);
      cpu_write("cw20b", 8'h20, 32'h12345678, 4'hF, 0);
      cpu_read("cr20a", 8'h20, 32'hDEADBEEF);
      cpu_write("cw20c", 8'h20, 32'h12345678, 4'hF, 1);
      cpu_read("cr20b", 8'h20, 32'h12345678);
      cpu_write("cw20d", 8'h20, 32'hFFFFFFFF, 4'b0010, 1);
      cpu_read("cr20c", 8'h20, 32'h1234FF78);

      // reset in J_RD with overrun set
      jtag(1, 0, 0, jdo_a(8'h20, 1));
      ta_b = 1'b1; jdo = jdo_b(32'h0);
      step();
      ta_b = 1'b0;
      chk("mid_overrun", jtag_overrun, 1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_mondreg", mon_dreg, 0);
      chk("mid_rst_monareg", mon_areg, 0);
      chk("mid_rst_ready", monitor_ready, 0);
      chk("mid_rst_overrun", jtag_overrun, 0);
      chk("mid_rst_readdata", avs_readdata, 0);
      chk("mid_rst_wait", avs_waitrequest, 1);
      step();
      reset_n = 1'b1;
      step(); step(); step();
      chk("post_rst_ready", monitor_ready, 0);
      chk("post_rst_mondreg", mon_dreg, 0);
      cpu_read("post_rst_ram", 8'h20, 32'h1234FF78);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
